alu_seq: RTL and testbench
==========================

# alu_seq

Register-file sequencer that drives the 4-bit combinational ALU and consumes its result. It accepts packed instructions over a valid/ready handshake and reads operands from a local 4x4-bit register file. It presents them to the ALU, writes the ALU output back to the register file, and returns the result over a second valid/ready handshake. It sits between the instruction source (testbench or upstream controller) and the ALU instance.

## Interface
- No parameters; data width fixed at 4 bits, 4 registers, 3-bit opcode.
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  instruction offered.
- in_ready  output  1  sequencer can accept an instruction.
- in_instr  input  10  [9] kind (0 = ALU op, 1 = load immediate); [8:6] op; [5:4] rd; [3:2] rs1; [1:0] rs2; for load, [3:0] is imm.
- alu_a  output  4  ALU operand a (registered).
- alu_b  output  4  ALU operand b (registered).
- alu_s  output  3  ALU opcode (registered).
- alu_y  input  4  ALU combinational result.
- res_valid  output  1  result available.
- res_ready  input  1  consumer accepts result.
- res_data  output  4  result value.
- res_rd  output  2  destination register of the result.
- done_cnt  output  8  completed-instruction count, wraps 255 -> 0.

## Operation
- FSM has three states: IDLE, EXEC, RESP. The reset state is IDLE.
- IDLE: in_ready = 1.
  - in_valid & kind = 0: latch rd; load alu_a = rf[rs1], alu_b = rf[rs2], alu_s = op; go to EXEC.
  - in_valid & kind = 1: write rf[rd] = imm; res_data = imm; res_rd = rd; go to RESP, bypassing the ALU. alu_* hold.
  - No in_valid: stay in IDLE.
- EXEC: in_ready = 0. At the end of the cycle, sample alu_y into res_data and into rf[rd]; res_rd = rd; go to RESP.
- RESP: in_ready = 0, res_valid = 1. res_data and res_rd are stable until the handshake completes.
  - res_ready = 1: done_cnt += 1; go to IDLE.
- Opcodes follow the ALU encoding: 000 add, 001 sub, 010 xor, 011 and, 100 or, 101 xnor, 110 shl by b, 111 shr by b.
  - All results are truncated to 4 bits. Sub wraps modulo 16. Any shift of 4 or more gives 0.
- rd may equal rs1 and/or rs2. Operands are read in IDLE, before the write-back, so the old values are used.
- Read-after-write: a register written by instruction N is visible to instruction N+1.
- alu_a, alu_b and alu_s hold their last values in IDLE and RESP.

## Timing
- Reset: state = IDLE; all rf = 0; alu_a = alu_b = 0; alu_s = 000; res_valid = 0; res_data = 0; res_rd = 0; done_cnt = 0; in_ready = 1 once rst is deasserted.
- ALU op latency: instruction accepted at edge 0. EXEC during cycle 1, with alu_* stable for the full cycle. res_valid = 1 from edge 2.
- Load latency: res_valid = 1 from edge 1.
- Minimum issue interval: 3 cycles for ALU ops, 2 for loads, when res_ready is held at 1.
- in_instr is ignored whenever in_ready = 0; no buffering.
- rst asserted mid-operation (EXEC or RESP): the result is dropped and res_valid falls immediately. No count increment. All state returns to reset values, including the register file.
- done_cnt increments only on a completed res_valid & res_ready handshake.

## Test plan
- Reset value check: assert rst → in_ready = 1, res_valid = 0, done_cnt = 0, alu_a = alu_b = 0, alu_s = 000.
- Loads and add: load r1 = 5, then r2 = 3; ADD r0 = r1 + r2. Required response:
  - Load results 5 (rd = 1) and 3 (rd = 2).
  - ADD result res_data = 8, res_rd = 0; alu_a = 5, alu_b = 3, alu_s = 000 during EXEC; res_valid at the 2nd edge after acceptance.
  - done_cnt = 3 at the end.
- Wrap and truncation, with r1 = 5, r2 = 3: SUB r3 = r2 - r1 → 4'hE; SHL r3 = r1 << r2 → 4'h8; load r2 = 4, then SHR r3 = r1 >> r2 → 0.
- Aliasing and read-after-write: r1 = 5; ADD r1 = r1 + r1 → 4'hA. Then ADD r0 = r1 + r1 → 4'h4, confirming the updated value is read.
- Backpressure: hold res_ready = 0 for 5 cycles after res_valid. Required response:
  - res_valid, res_data and res_rd are stable; in_ready = 0; a new in_valid is ignored.
  - On release, exactly one count increment.
- Reset mid-op: assert rst during EXEC → res_valid never rises, done_cnt = 0, rf cleared. A following ADD r0 = r1 + r2 → 0.

Source files
------------

// File: rtl/alu_seq.sv
// Instruction sequencer for a 4-bit combinational ALU: reads operands from a
// 4x4 register file, drives the ALU, writes the result back and returns it.
module alu_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [9:0] in_instr,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [2:0] alu_s,
  input  logic [3:0] alu_y,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [3:0] res_data,
  output logic [1:0] res_rd,
  output logic [7:0] done_cnt
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t     r_state;
  logic [3:0] r_rf [4];
  logic [1:0] r_rd;

  logic       w_kind;
  logic [2:0] w_op;
  logic [1:0] w_rd;
  logic [1:0] w_rs1;
  logic [1:0] w_rs2;
  logic [3:0] w_imm;

  assign w_kind = in_instr[9];
  assign w_op   = in_instr[8:6];
  assign w_rd   = in_instr[5:4];
  assign w_rs1  = in_instr[3:2];
  assign w_rs2  = in_instr[1:0];
  assign w_imm  = in_instr[3:0];

  assign in_ready  = (r_state == IDLE);
  assign res_valid = (r_state == RESP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_rd     <= '0;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_s    <= '0;
      res_data <= '0;
      res_rd   <= '0;
      done_cnt <= '0;
      // NOTE: the register file is architecturally cleared by reset, so it is
      // built from flops here rather than a RAM that cannot be reset.
      for (int i = 0; i < 4; i++) r_rf[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so operands read in IDLE
      // always see the register file as it was before this edge's write.
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            if (!w_kind) begin
              alu_a   <= r_rf[w_rs1];
              alu_b   <= r_rf[w_rs2];
              alu_s   <= w_op;
              r_rd    <= w_rd;
              r_state <= EXEC;
            end else begin
              r_rf[w_rd] <= w_imm;
              res_data   <= w_imm;
              res_rd     <= w_rd;
              r_state    <= RESP;
            end
          end
        end
        EXEC: begin
          r_rf[r_rd] <= alu_y;
          res_data   <= alu_y;
          res_rd     <= r_rd;
          r_state    <= RESP;
        end
        RESP: begin
          if (res_ready) begin
            done_cnt <= done_cnt + 8'd1;
            r_state  <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: models the ALU, runs a table of
// instructions through a scoreboard, then covers backpressure and mid-op reset.
module tb_alu_seq;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [9:0] in_instr;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [2:0] alu_s;
  logic [3:0] alu_y;
  logic       res_valid;
  logic       res_ready;
  logic [3:0] res_data;
  logic [1:0] res_rd;
  logic [7:0] done_cnt;

  alu_seq dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_instr (in_instr),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_s    (alu_s),
    .alu_y    (alu_y),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_data (res_data),
    .res_rd   (res_rd),
    .done_cnt (done_cnt)
  );

  typedef struct packed {
    logic [9:0] instr;
    logic [3:0] exp_a;
    logic [3:0] exp_b;
    logic [3:0] exp_data;
    logic [1:0] exp_rd;
  } vec_t;

  typedef struct packed {
    logic [3:0] d;
    logic [1:0] rd;
  } res_t;

  res_t sb [$];
  vec_t vecs [14];
  int   n_tests = 0;
  int   n_fail  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] alu_f(input logic [3:0] a, input logic [3:0] b,
                                       input logic [2:0] s);
    case (s)
      3'd0: alu_f = a + b;
      3'd1: alu_f = a - b;
      3'd2: alu_f = a ^ b;
      3'd3: alu_f = a & b;
      3'd4: alu_f = a | b;
      3'd5: alu_f = ~(a ^ b);
      3'd6: alu_f = (b >= 4'd4) ? 4'd0 : 4'(a << b);
      default: alu_f = (b >= 4'd4) ? 4'd0 : 4'(a >> b);
    endcase
  endfunction

  always_comb alu_y = alu_f(alu_a, alu_b, alu_s);

  function automatic logic [9:0] mk_alu(input logic [2:0] op, input logic [1:0] rd,
                                        input logic [1:0] rs1, input logic [1:0] rs2);
    return {1'b0, op, rd, rs1, rs2};
  endfunction

  function automatic logic [9:0] mk_ld(input logic [1:0] rd, input logic [3:0] imm);
    return {1'b1, 3'b000, rd, imm};
  endfunction

  function automatic vec_t mkv(input logic [9:0] instr, input logic [3:0] a,
                               input logic [3:0] b, input logic [3:0] d,
                               input logic [1:0] rd);
    return {instr, a, b, d, rd};
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Response monitor: pops one expectation per completed result handshake.
  always @(negedge clk) begin : monitor
    res_t e;
    if (!rst && res_valid && res_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_result", 8'd1, 8'd0);
      end else begin
        e = sb.pop_front();
        check("res_data", {4'h0, res_data}, {4'h0, e.d});
        check("res_rd", {6'h0, res_rd}, {6'h0, e.rd});
      end
    end
  end

  task automatic issue(input logic [9:0] instr, input bit push, input res_t exp);
    int n = 0;
    in_valid = 1'b1;
    in_instr = instr;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("accept_timeout", 8'd0, 8'd1);
    @(posedge clk);
    if (push) sb.push_back(exp);
    #1 in_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    issue(v.instr, 1'b1, {v.exp_data, v.exp_rd});
    @(negedge clk);
    if (!v.instr[9]) begin
      check("exec_res_valid", {7'h0, res_valid}, 8'd0);
      check("exec_alu_a", {4'h0, alu_a}, {4'h0, v.exp_a});
      check("exec_alu_b", {4'h0, alu_b}, {4'h0, v.exp_b});
      check("exec_alu_s", {5'h0, alu_s}, {5'h0, v.instr[8:6]});
      @(negedge clk);
    end
    check("resp_res_valid", {7'h0, res_valid}, 8'd1);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_instr  = '0;
    res_ready = 1'b1;

    vecs[0]  = mkv(mk_ld(2'd1, 4'd5),          4'h0, 4'h0, 4'h5, 2'd1);
    vecs[1]  = mkv(mk_ld(2'd2, 4'd3),          4'h0, 4'h0, 4'h3, 2'd2);
    vecs[2]  = mkv(mk_alu(3'd0, 2'd0, 2'd1, 2'd2), 4'h5, 4'h3, 4'h8, 2'd0);
    vecs[3]  = mkv(mk_alu(3'd1, 2'd3, 2'd2, 2'd1), 4'h3, 4'h5, 4'hE, 2'd3);
    vecs[4]  = mkv(mk_alu(3'd6, 2'd3, 2'd1, 2'd2), 4'h5, 4'h3, 4'h8, 2'd3);
    vecs[5]  = mkv(mk_ld(2'd2, 4'd4),          4'h0, 4'h0, 4'h4, 2'd2);
    vecs[6]  = mkv(mk_alu(3'd7, 2'd3, 2'd1, 2'd2), 4'h5, 4'h4, 4'h0, 2'd3);
    vecs[7]  = mkv(mk_alu(3'd0, 2'd1, 2'd1, 2'd1), 4'h5, 4'h5, 4'hA, 2'd1);
    vecs[8]  = mkv(mk_alu(3'd0, 2'd0, 2'd1, 2'd1), 4'hA, 4'hA, 4'h4, 2'd0);
    vecs[9]  = mkv(mk_alu(3'd2, 2'd3, 2'd1, 2'd0), 4'hA, 4'h4, 4'hE, 2'd3);
    vecs[10] = mkv(mk_alu(3'd3, 2'd2, 2'd1, 2'd3), 4'hA, 4'hE, 4'hA, 2'd2);
    vecs[11] = mkv(mk_alu(3'd4, 2'd0, 2'd0, 2'd2), 4'h4, 4'hA, 4'hE, 2'd0);
    vecs[12] = mkv(mk_alu(3'd5, 2'd3, 2'd1, 2'd0), 4'hA, 4'hE, 4'hB, 2'd3);
    vecs[13] = mkv(mk_alu(3'd6, 2'd0, 2'd1, 2'd3), 4'hA, 4'hB, 4'h0, 2'd0);

    // Reset values
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", {7'h0, in_ready}, 8'd1);
    check("rst_res_valid", {7'h0, res_valid}, 8'd0);
    check("rst_done_cnt", done_cnt, 8'd0);
    check("rst_alu_a", {4'h0, alu_a}, 8'd0);
    check("rst_alu_b", {4'h0, alu_b}, 8'd0);
    check("rst_alu_s", {5'h0, alu_s}, 8'd0);

    // Table of loads and ALU ops, one result handshake each
    for (int i = 0; i < 14; i++) begin
      run_vec(vecs[i]);
      if (i == 2) begin
        @(posedge clk);
        #1 check("done_cnt_after_add", done_cnt, 8'd3);
      end
    end
    @(posedge clk);
    #1 check("done_cnt_table", done_cnt, 8'd14);

    // Backpressure: result held for 5 cycles, competing instruction ignored
    res_ready = 1'b0;
    issue(mk_ld(2'd0, 4'd9), 1'b1, {4'h9, 2'd0});
    in_valid = 1'b1;
    in_instr = mk_ld(2'd1, 4'd7);
    repeat (5) begin
      @(negedge clk);
      check("bp_res_valid", {7'h0, res_valid}, 8'd1);
      check("bp_res_data", {4'h0, res_data}, 8'h09);
      check("bp_res_rd", {6'h0, res_rd}, 8'd0);
      check("bp_in_ready", {7'h0, in_ready}, 8'd0);
    end
    in_valid = 1'b0;
    check("bp_done_cnt_held", done_cnt, 8'd14);
    @(posedge clk);
    #1 res_ready = 1'b1;
    @(posedge clk);
    #1 check("bp_done_cnt_release", done_cnt, 8'd15);
    @(posedge clk);
    #1 check("bp_done_cnt_once", done_cnt, 8'd15);
    check("bp_in_ready_after", {7'h0, in_ready}, 8'd1);
    // r1 must still hold 0xA: the ignored load would have made it 7
    run_vec(mkv(mk_alu(3'd0, 2'd2, 2'd1, 2'd1), 4'hA, 4'hA, 4'h4, 2'd2));
    @(posedge clk);
    #1 check("done_cnt_after_bp", done_cnt, 8'd16);

    // Reset during EXEC drops the result and clears everything
    issue(mk_alu(3'd0, 2'd0, 2'd1, 2'd2), 1'b0, '0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_res_valid", {7'h0, res_valid}, 8'd0);
    check("midrst_done_cnt", done_cnt, 8'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_res_valid", {7'h0, res_valid}, 8'd0);
    end
    check("post_rst_alu_a", {4'h0, alu_a}, 8'd0);
    check("post_rst_done_cnt", done_cnt, 8'd0);
    run_vec(mkv(mk_alu(3'd0, 2'd0, 2'd1, 2'd2), 4'h0, 4'h0, 4'h0, 2'd0));
    @(posedge clk);
    #1 check("done_cnt_final", done_cnt, 8'd1);
    check("scoreboard_drained", 8'(sb.size()), 8'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
